// File: rtl/proc_pkg.sv
// Shared definitions for the 4-bit processor fetch/execute controller.
// Contents: sequencer state enum, HALT opcode, data RAM word addresses and
// the opcode / data / program-counter widths.
// Optional feature macro: SEQ_STEP_EN adds the PAUSE state to the enum.
package proc_pkg;

  localparam int OPC_W  = 4;
  localparam int DATA_W = 8;
  localparam int PC_W   = 3;

  localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

  localparam logic RAM_ADDR_OPND = 1'b0;
  localparam logic RAM_ADDR_RES  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
`ifdef SEQ_STEP_EN
    ST_WB,
    ST_PAUSE
`else
    ST_WB
`endif
  } state_t;

endpackage

// File: rtl/seq_delay_cnt.sv
// Loadable down-counter that marks the last EXEC cycle.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : start a new countdown of LAT cycles (asserted the cycle before EXEC)
//   expire   : high during the LAT-th cycle after load, i.e. the final EXEC cycle
module seq_delay_cnt #(
  parameter int unsigned LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int unsigned W = (LAT > 1) ? $clog2(LAT) : 1;

  logic [W-1:0] cnt;
  logic         active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= W'(LAT - 1);
      active <= 1'b1;
    end else if (active) begin
      if (cnt == '0) begin
        active <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign expire = active && (cnt == '0);

endmodule

// File: rtl/program_sequencer.sv
// Fetch/execute controller: steps pc through the program ROM, drives the ALU
// opcode, loads operands into RAM word 0 and writes each ALU result back to
// RAM word 1 and to the result register. All outputs are registered.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   start, load_req      : one-cycle command pulses, honoured only in IDLE
//   a_in, b_in           : operand nibbles, written as {b_in,a_in}
//   rom_addr, rom_data   : program ROM port (data valid one cycle after addr)
//   ram_we/addr/wdata    : data RAM write port
//   alu_op, alu_result   : ALU opcode out, ALU result in
//   result, result_valid : last written-back result and its update pulse
//   busy, done, pc       : status
// Optional feature macro: SEQ_STEP_EN adds input step and a PAUSE state that
// waits for step after each non-final writeback.
module program_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned PROG_LEN = 5,
  parameter int unsigned ALU_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_req,
`ifdef SEQ_STEP_EN
  input  logic              step,
`endif
  input  logic [3:0]        a_in,
  input  logic [3:0]        b_in,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [OPC_W-1:0]  rom_data,
  output logic              ram_we,
  output logic              ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [OPC_W-1:0]  alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              busy,
  output logic              done,
  output logic [PC_W-1:0]   pc
);

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);

  state_t state;
  logic   cnt_load;
  logic   exec_done;

  assign cnt_load = (state == ST_DECODE) && (rom_data != OPC_HALT);

  seq_delay_cnt #(.LAT(ALU_LAT)) u_delay (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .expire (exec_done)
  );

  // Outputs are assigned on the transition into the state they belong to,
  // so each state's outputs are visible for exactly the cycles spent in it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      pc           <= '0;
      rom_addr     <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= RAM_ADDR_OPND;
      ram_wdata    <= '0;
      alu_op       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      ram_we       <= 1'b0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_req) begin
            ram_we    <= 1'b1;
            ram_addr  <= RAM_ADDR_OPND;
            ram_wdata <= {b_in, a_in};
          end else if (start) begin
            pc       <= '0;
            rom_addr <= '0;
            ram_addr <= RAM_ADDR_OPND;
            busy     <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (rom_data == OPC_HALT) begin
            done  <= 1'b1;
            pc    <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            alu_op <= rom_data;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            result       <= alu_result;
            ram_we       <= 1'b1;
            ram_addr     <= RAM_ADDR_RES;
            ram_wdata    <= alu_result;
            result_valid <= 1'b1;
            done         <= (pc == PC_LAST);
            state        <= ST_WB;
          end
        end
        ST_WB: begin
          ram_addr <= RAM_ADDR_OPND;
          if (pc == PC_LAST) begin
            pc    <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            pc       <= pc + 1'b1;
            rom_addr <= pc + 1'b1;
`ifdef SEQ_STEP_EN
            state    <= ST_PAUSE;
`else
            state    <= ST_FETCH;
`endif
          end
        end
`ifdef SEQ_STEP_EN
        ST_PAUSE: begin
          if (step) begin
            state <= ST_FETCH;
          end
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Fetch/execute controller for the 4-bit processor datapath. It steps a program counter through the program ROM, drives the ALU opcode from each fetched word, and owns the data RAM port. Operands are loaded into RAM word 0 on request, and each ALU result is written back to RAM word 1 and to a result register. It sits between the board-level key/switch logic and the program_rom / data_ram / ALU instances, replacing manual key-stepped opcode selection.

## Interface
- PROG_LEN, 5: number of program steps; pc runs 0..PROG_LEN-1, legal range 1..8
- ALU_LAT, 1: cycles from alu_op stable to alu_result valid, legal range 1..4
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins program execution from pc=0
- load_req  in  1  one-cycle pulse; writes {b_in,a_in} to RAM word 0
- a_in  in  4  operand A (low nibble)
- b_in  in  4  operand B (high nibble)
- rom_addr  out  3  program ROM address
- rom_data  in  4  program ROM word, valid 1 cycle after rom_addr
- ram_we  out  1  data RAM write enable
- ram_addr  out  1  data RAM address (0 = operands, 1 = result)
- ram_wdata  out  8  data RAM write data
- alu_op  out  4  ALU opcode
- alu_result  in  8  ALU output
- result  out  8  last written-back ALU result
- result_valid  out  1  one-cycle pulse when result updates
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at program end or HALT
- pc  out  3  current program counter

## Operation
- Reset values: all outputs 0; state IDLE; pc 0.
- States:
  - IDLE: accepts load_req/start.
  - FETCH: rom_addr=pc, ram_addr=0.
  - DECODE: latch rom_data into alu_op.
  - EXEC: hold for ALU_LAT cycles.
  - WB: result<=alu_result, ram_we=1, ram_addr=1, ram_wdata=alu_result, result_valid=1.
- IDLE + load_req: single-cycle write, ram_we=1, ram_addr=0, ram_wdata={b_in,a_in}; stay in IDLE.
- IDLE + start: pc<=0, go to FETCH.
- IDLE with load_req and start in the same cycle: the load is performed and start is dropped.
- start and load_req while busy: ignored. The sequencer owns the RAM port while busy.
- DECODE, rom_data==4'hF (HALT): no EXEC/WB; done pulse, pc<=0, go to IDLE.
- WB, pc==PROG_LEN-1: pc<=0, done pulse in the same cycle as result_valid, go to IDLE.
- WB otherwise: pc<=pc+1, go to FETCH.
- alu_op holds its last value in IDLE, so the ALU output stays displayed.
- rst mid-program: immediate return to IDLE, no pending write completes, result is cleared.

## Timing
- start at cycle 0 → FETCH at cycle 1, DECODE at 2, EXEC at 3..2+ALU_LAT, WB at 3+ALU_LAT.
- Per-instruction period is 3+ALU_LAT cycles; 4 cycles at the default.
- Full program, no HALT: PROG_LEN×(3+ALU_LAT) cycles from the first FETCH to the done pulse.
- load_req: RAM written on the next rising edge; ram_rdata reflects it 1 cycle later.
- Every output is registered; no combinational path from any input to any output.

## Configuration
- SEQ_STEP_EN defined:
  - Adds input step (1 bit, one-cycle pulse) and state PAUSE.
  - After each WB that does not end the program, the FSM enters PAUSE and waits for step before going to FETCH; busy stays high.
  - start is ignored in PAUSE.
- SEQ_STEP_EN undefined: no step port, no PAUSE state; instructions run back-to-back.

## Structure
- Shared package proc_pkg holds:
  - the state enum
  - OPC_HALT = 4'hF
  - RAM_ADDR_OPND = 1'b0 and RAM_ADDR_RES = 1'b1
  - opcode width 4, data width 8, pc width 3
- One sub-module, seq_delay_cnt: a loadable down-counter that produces the EXEC-done strobe after ALU_LAT cycles.

## Test plan
- load_req with a_in=3, b_in=5 → ram_we=1, ram_addr=0, ram_wdata=8'h53 for exactly 1 cycle; busy stays 0.
- ROM 0,1,2,3,4, ALU model result = op+8'h10, start → 5 result_valid pulses with result 8'h10..8'h14 at 4-cycle spacing; done coincides with the 5th pulse; pc returns to 0.
- ROM word 2 = 4'hF → 2 writebacks, then done 2 cycles after the third FETCH; no third ram_we.
- start and load_req during busy → no extra ram_we at address 0; the program completes unchanged.
- rst asserted in EXEC of step 2 → all outputs 0 asynchronously; the next start re-runs from pc=0.
- SEQ_STEP_EN defined → FSM holds in PAUSE after each WB until step; a 3-cycle step gap adds exactly 3 cycles per instruction.
